// File: rtl/alu_mdu.sv
`timescale 1ns/1ps
// alu_mdu: RV integer ALU plus iterative M-extension engine.
// Base ops finish one cycle after accept. Multiply and divide take a fixed
// XLEN+1 cycles. Multiply is shift-add and divide is restoring, one bit per cycle.
module alu_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [1:0]      flags,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              accept;
  logic [2:0]        op_q;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   opnd_q;      // multiplicand magnitude or divisor magnitude
  logic [2*XLEN-1:0] acc_q;       // {partial sum | remainder, multiplier | quotient}
  logic              neg_q;       // sign for product or quotient
  logic              neg_r_q;     // sign for remainder
  logic [XLEN-1:0]   result_q;
  logic [1:0]        flags_q;
  logic              last_iter;

  // Only func7[0] and func7[5] carry meaning.
  logic unused_f7;
  assign unused_f7 = ^{func7[6], func7[4:1]};

  function automatic logic [1:0] calc_flags(input logic [XLEN-1:0] r);
    return {r[XLEN-1], (r == '0)};
  endfunction

  // ---------------- base ALU (evaluated on the incoming operands) ----------
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] sra_res;
  logic [XLEN-1:0] base_res;

  assign shamt   = b[SHW-1:0];
  assign sra_res = $signed(a) >>> shamt;

  // Combinational result of the single-cycle operations.
  always_comb begin
    base_res = '0;
    case (func3)
      3'd0: base_res = func7[5] ? (a - b) : (a + b);
      3'd1: base_res = a << shamt;
      3'd2: base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      3'd3: base_res = {{(XLEN-1){1'b0}}, (a < b)};
      3'd4: base_res = a ^ b;
      3'd5: base_res = func7[5] ? sra_res : (a >> shamt);
      3'd6: base_res = a | b;
      default: base_res = a & b;
    endcase
  end

  // ---------------- M-op operand preparation ------------------------------
  logic            sa_signed, sb_signed, a_neg, b_neg, b_zero;
  logic [XLEN-1:0] a_mag, b_mag;

  // Decide which operands are treated as signed for the requested M op.
  always_comb begin
    if (func3[2]) begin
      sa_signed = ~func3[0];
      sb_signed = ~func3[0];
    end else begin
      sa_signed = (func3[1:0] != 2'b11);
      sb_signed = ~func3[1];
    end
  end

  assign a_neg  = sa_signed & a[XLEN-1];
  assign b_neg  = sb_signed & b[XLEN-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  assign b_zero = (b == '0);

  // ---------------- one iteration of multiply / divide --------------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nx;
  logic [XLEN:0]     r_shift;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_nx;
  logic [2*XLEN-1:0] acc_nx;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_nx   = {mul_sum, acc_q[XLEN-1:1]};
  assign r_shift  = acc_q[2*XLEN-1:XLEN-1];
  assign div_ge   = (r_shift >= {1'b0, opnd_q});
  assign div_diff = r_shift[XLEN-1:0] - opnd_q;
  assign div_nx   = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                           : {r_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
  assign acc_nx   = (state_q == S_MUL) ? mul_nx : div_nx;

  // Apply signs to the post-iteration value so the last iteration delivers the result.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, mul_res, div_res, fin_res;

  assign prod    = neg_q ? -acc_nx : acc_nx;
  assign mul_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign quo     = acc_nx[XLEN-1:0];
  assign rem     = acc_nx[2*XLEN-1:XLEN];
  assign div_res = ~op_q[1] ? (neg_q ? -quo : quo) : (neg_r_q ? -rem : rem);
  assign fin_res = (state_q == S_MUL) ? mul_res : div_res;

  assign last_iter = (cnt_q == CW'(XLEN-1));
  assign accept    = in_valid & in_ready;

  // ---------------- FSM ---------------------------------------------------
  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: accept from IDLE/DONE, count out the iterative ops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (!func7[0])     state_d = S_DONE;
          else if (func3[2]) state_d = S_DIV;
          else               state_d = S_MUL;
        end else if (state_q == S_DONE && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_MUL, S_DIV: if (last_iter) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and status outputs derived from the state.
  always_comb begin
    in_ready  = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
    out_valid = (state_q == S_DONE);
    busy      = (state_q == S_MUL) || (state_q == S_DIV);
  end

  // ---------------- datapath registers -----------------------------------
  // Capture operands at accept, iterate in MUL/DIV, hold the result in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      cnt_q    <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
      flags_q  <= 2'b01;
    end else if (accept) begin
      op_q  <= func3;
      cnt_q <= '0;
      if (!func7[0]) begin
        result_q <= base_res;
        flags_q  <= calc_flags(base_res);
      end else if (!func3[2]) begin
        acc_q   <= {{XLEN{1'b0}}, b_mag};
        opnd_q  <= a_mag;
        neg_q   <= a_neg ^ b_neg;
        neg_r_q <= 1'b0;
      end else begin
        acc_q   <= {{XLEN{1'b0}}, a_mag};
        opnd_q  <= b_mag;
        // Divide by zero keeps the all-ones quotient unsigned.
        neg_q   <= (a_neg ^ b_neg) & ~b_zero;
        neg_r_q <= a_neg;
      end
    end else if (state_q == S_MUL || state_q == S_DIV) begin
      acc_q <= acc_nx;
      cnt_q <= cnt_q + 1'b1;
      if (last_iter) begin
        result_q <= fin_res;
        flags_q  <= calc_flags(fin_res);
      end
    end
  end

  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_alu_mdu.sv
`timescale 1ns/1ps
// Scoreboard bench for alu_mdu: the driver pushes expected results at accept,
// an independent monitor pops and compares on every output handshake.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  func3 = '0;
  logic [6:0]  func7 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [1:0]  flags;
  logic        busy;

  alu_mdu #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .func3(func3), .func7(func7),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [1:0]  flg;
    int          acc_cyc;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] fl(input logic [31:0] r);
    return {r[31], (r == 32'd0)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s", name);
  endtask

  // Present one request; the expected response is queued when acceptance is certain.
  task automatic send(input string name, input logic [31:0] aa, input logic [31:0] bb,
                      input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] exp, input int lat);
    int  waited = 0;
    bit  ok = 0;
    exp_t e;
    a = aa; b = bb; func3 = f3; func7 = f7; in_valid = 1'b1;
    while (!ok && waited < 200) begin
      @(negedge clk);
      if (in_ready) begin
        e.res = exp; e.flg = fl(exp); e.acc_cyc = cyc; e.lat = lat; e.name = name;
        sb.push_back(e);
        ok = 1;
      end
      waited++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) fail_now({name, "_accept_timeout"});
  endtask

  task automatic drain(input string name);
    int w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    #1;
    if (sb.size() != 0) fail_now({name, "_drain_timeout"});
  endtask

  // Monitor: latency on first appearance, stability under backpressure, value on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_out_valid");
      end else begin
        if (!seen) begin
          check({sb[0].name, "_latency"}, 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
          seen = 1;
        end
        if (out_ready) begin
          check({sb[0].name, "_result"}, result, sb[0].res);
          check({sb[0].name, "_flags"}, flags, sb[0].flg);
          void'(sb.pop_front());
          seen = 0;
        end else begin
          check({sb[0].name, "_held_result"}, result, sb[0].res);
          check({sb[0].name, "_held_in_ready"}, in_ready, 1'b0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bok;
    int c0;
    int w;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 32'h0);
    check("rst_flags", flags, 2'b01);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Base ops, issued back-to-back with out_ready high
    c0 = cyc;
    send("add_ovf", 32'h7FFFFFFF, 32'h1, 3'd0, 7'h00, 32'h80000000, 1);
    send("sub_zero", 32'd5, 32'd5, 3'd0, 7'h20, 32'h0, 1);
    send("slt", 32'hFFFFFFFF, 32'd1, 3'd2, 7'h00, 32'd1, 1);
    send("sltu", 32'hFFFFFFFF, 32'd1, 3'd3, 7'h00, 32'd0, 1);
    send("sra", 32'h80000000, 32'd4, 3'd5, 7'h20, 32'hF8000000, 1);
    send("xor", 32'hF0F0F0F0, 32'h0FF00FF0, 3'd4, 7'h00, 32'hFF00FF00, 1);
    check("b2b_throughput", 64'(cyc - c0), 64'd6);
    send("or", 32'h12340000, 32'h00005678, 3'd6, 7'h00, 32'h12345678, 1);
    send("and", 32'hFFFF0000, 32'h12345678, 3'd7, 7'h00, 32'h12340000, 1);
    send("sll", 32'd1, 32'd31, 3'd1, 7'h00, 32'h80000000, 1);
    send("sll_wrap", 32'd1, 32'd33, 3'd1, 7'h00, 32'd2, 1);
    send("srl", 32'h80000000, 32'd31, 3'd5, 7'h00, 32'd1, 1);
    send("add_f7_ign", 32'd3, 32'd4, 3'd0, 7'h40, 32'd7, 1);
    drain("base");

    // MUL timing: busy for 32 cycles, result on cycle 33
    send("mul", 32'hFFFFFFFF, 32'd2, 3'd0, 7'h01, 32'hFFFFFFFE, 33);
    bok = 1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (!busy || out_valid) bok = 0;
    end
    check("mul_busy_window", bok, 1'b1);
    @(negedge clk);
    check("mul_busy_done", busy, 1'b0);
    @(posedge clk); #1;
    send("mulh", 32'hFFFFFFFF, 32'd2, 3'd1, 7'h01, 32'hFFFFFFFF, 33);
    send("mulhsu", 32'hFFFFFFFF, 32'd2, 3'd2, 7'h01, 32'hFFFFFFFF, 33);
    send("mulhu", 32'hFFFFFFFF, 32'd2, 3'd3, 7'h01, 32'h00000001, 33);
    send("mul_f7_5_ign", 32'd6, 32'd7, 3'd0, 7'h21, 32'd42, 33);

    // Divide corner cases
    send("div_by0", 32'd7, 32'd0, 3'd4, 7'h01, 32'hFFFFFFFF, 33);
    send("rem_by0", 32'd7, 32'd0, 3'd6, 7'h01, 32'd7, 33);
    send("divu_by0", 32'd7, 32'd0, 3'd5, 7'h01, 32'hFFFFFFFF, 33);
    send("remu_by0", 32'd7, 32'd0, 3'd7, 7'h01, 32'd7, 33);
    send("div_ovf", 32'h80000000, 32'hFFFFFFFF, 3'd4, 7'h01, 32'h80000000, 33);
    send("rem_ovf", 32'h80000000, 32'hFFFFFFFF, 3'd6, 7'h01, 32'h0, 33);
    send("div_neg", 32'hFFFFFFF9, 32'd2, 3'd4, 7'h01, 32'hFFFFFFFD, 33);
    send("rem_neg", 32'hFFFFFFF9, 32'd2, 3'd6, 7'h01, 32'hFFFFFFFF, 33);
    send("divu", 32'd100, 32'd7, 3'd5, 7'h01, 32'd14, 33);
    send("remu", 32'd100, 32'd7, 3'd7, 7'h01, 32'd2, 33);
    drain("mdu");

    // Output backpressure for 5 cycles with a pending request
    out_ready = 1'b0;
    send("div_bp", 32'hFFFFFFF9, 32'd2, 3'd4, 7'h01, 32'hFFFFFFFD, 33);
    w = 0;
    while (!out_valid && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (!out_valid) fail_now("bp_wait_timeout");
    @(posedge clk); #1;
    a = 32'd1; b = 32'd1; func3 = 3'd0; func7 = 7'h00; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid_held", out_valid, 1'b1);
      check("bp_flags_held", flags, 2'b10);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send("add_after_bp", 32'd1, 32'd1, 3'd0, 7'h00, 32'd2, 1);
    drain("bp");

    // Reset in the middle of a divide
    send("div_aborted", 32'd100, 32'd3, 3'd4, 7'h01, 32'd33, 33);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send("add_after_rst", 32'd20, 32'd22, 3'd0, 7'h00, 32'd42, 1);
    drain("rst");
    repeat (40) @(posedge clk);
    #1;
    check("idle_after_rst", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised successor to the single-cycle RV32I integer ALU. Adds the RV M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) through an iterative, one-bit-per-cycle multiply/divide engine.
- Sits in the execute stage. Takes operands and func3/func7 from decode over a valid/ready handshake. Returns a registered result plus {negative, zero} flags over a second valid/ready handshake to writeback/branch logic.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64. Shift amount uses b[$clog2(XLEN)-1:0].

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request this cycle
- a  input  XLEN  operand rs1
- b  input  XLEN  operand rs2 / immediate
- func3  input  3  operation select
- func7  input  7  func7[0]=1 selects M-extension; func7[5]=1 selects SUB/SRA when func7[0]=0
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  XLEN  operation result
- flags  output  2  {negative, zero} of result
- busy  output  1  high in MUL or DIV state

Behaviour:
- Reset (rst_n low, async): state=IDLE; out_valid=0, result=0, flags=2'b01, busy=0. Reset mid-iteration aborts the operation; no result is produced.
- States:
  - IDLE, MUL, DIV, DONE.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Accept = in_valid && in_ready. Operands, func3 and func7 are captured at accept.
- Base ops (func7[0]=0), by func3:
  - 0 ADD/SUB; 1 SLL; 2 SLT (signed a<b → 1, else 0); 3 SLTU (unsigned a<b); 4 XOR; 5 SRL/SRA; 6 OR; 7 AND.
  - Arithmetic is modulo 2^XLEN.
  - Result is computed at accept and registered; state→DONE. Latency 1: out_valid is high the cycle after accept.
- M ops (func7[0]=1):
  - func3 0–3 (MUL, MULH, MULHSU, MULHU) → state MUL. func3 4–7 (DIV, DIVU, REM, REMU) → state DIV.
  - Signed operands are converted to magnitudes at accept; the sign is applied at completion.
  - MUL: shift-add over XLEN iterations into a 2·XLEN accumulator. MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - DIV: restoring division, XLEN iterations. Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - An iteration counter runs 0..XLEN-1. After the last iteration, state→DONE. out_valid is high exactly XLEN+1 cycles after accept, fixed for all M ops including corner cases.
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → a.
  - Signed overflow (a = most-negative, b = -1): DIV → a; REM → 0.
  - Inputs in MUL/DIV states are ignored (in_ready=0).
- DONE state:
  - result and flags are held stable while out_valid && !out_ready.
  - out_ready=1 with no new accept → IDLE, out_valid=0.
  - out_ready=1 with a simultaneous accept → new op is captured in the same cycle. A base op keeps out_valid high the next cycle with the new result (back-to-back, one op/cycle). An M op → MUL/DIV, out_valid=0.
- Flags are registered with result: zero = (result==0); negative = result[XLEN-1].
- func7 bits other than [0] and [5] are ignored. func7[5] is ignored for M ops.

Test Plan:
- Base ops, XLEN=32:
  - ADD 0x7FFFFFFF+1 → result 0x80000000, flags 2'b10, one cycle after accept.
  - SUB 5-5 → 0, flags 2'b01.
  - SLT a=0xFFFFFFFF, b=1 → 1.
  - SLTU same operands → 0.
  - SRA 0x80000000 by 4 → 0xF8000000.
- Back-to-back base ops with out_ready held 1: in_valid every cycle → one result per cycle, in order.
- MUL/MULH a=0xFFFFFFFF (-1), b=2:
  - MUL → 0xFFFFFFFE; MULH → 0xFFFFFFFF; MULHU → 0x00000001.
  - out_valid at exactly cycle 33 after accept; busy high cycles 1–32.
- DIV corner cases:
  - DIV 7/0 → 0xFFFFFFFF; REM 7/0 → 7.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
  - DIV -7/2 → -3 (0xFFFFFFFD); REM → -1.
- Output backpressure: out_ready low 5 cycles after completion → result, flags and out_valid stable; in_ready=0; no new accept until out_ready rises.
- Reset mid-DIV at iteration 10: rst_n low → out_valid and busy drop immediately. After release, a new ADD completes normally with no stale result.
